// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl
//   Registered mode/field controller for the digital clock. Owns the operating
//   mode FSM, the one-hot field-select pointer, button edge detection, the
//   SET-mode inactivity timeout and per-field inc/dec/en steering into a chain
//   of NUM_FIELDS cascaded digit counters.
//
//   Build option: CLOCK_MODE_CTRL_AUTO_REPEAT_EN enables auto-repeat of a held
//   inc/dec button in SET. Without it each button rise yields exactly one pulse.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   sec_tick  in   one-cycle time-base strobe
//   btn_mode  in   mode button level (synchronised, debounced)
//   btn_next  in   field-advance button level
//   btn_inc   in   increment button level
//   btn_dec   in   decrement button level
//   done_inc  in   [NUM_FIELDS-2:0] carry-out of field i
//   done_dec  in   [NUM_FIELDS-2:0] borrow-out of field i
//   cnt_zero  in   all fields equal zero
//   mode      out  [1:0] current mode
//   select    out  [NUM_FIELDS-1:0] one-hot field pointer
//   inc       out  [NUM_FIELDS-1:0] per-field increment enable
//   dec       out  [NUM_FIELDS-1:0] per-field decrement enable
//   en        out  [NUM_FIELDS-1:0] per-field load/display enable
//   blink     out  blink phase for the selected field
//   alarm     out  one-cycle pulse at end of countdown
//
// State   | meaning
// --------+-----------------------------------------------------------
// RUN  00 | normal timekeeping, field 0 counts sec_tick, carries ripple
// SET  01 | user edits the selected field, blink active, timeout armed
// HOLD 10 | counters frozen, all fields displayed
// CDOWN 11| countdown on sec_tick until cnt_zero, then alarm and HOLD

module clock_mode_ctrl #(
  parameter int NUM_FIELDS    = 6,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int TIMEOUT       = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sec_tick,
  input  logic                  btn_mode,
  input  logic                  btn_next,
  input  logic                  btn_inc,
  input  logic                  btn_dec,
  input  logic [NUM_FIELDS-2:0] done_inc,
  input  logic [NUM_FIELDS-2:0] done_dec,
  input  logic                  cnt_zero,
  output logic [1:0]            mode,
  output logic [NUM_FIELDS-1:0] select,
  output logic [NUM_FIELDS-1:0] inc,
  output logic [NUM_FIELDS-1:0] dec,
  output logic [NUM_FIELDS-1:0] en,
  output logic                  blink,
  output logic                  alarm
);

  localparam int N    = NUM_FIELDS;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  generate
    if (NUM_FIELDS < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || TIMEOUT < 1) begin : g_bad_param
      $error("clock_mode_ctrl: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_SET   = 2'b01,
    MODE_HOLD  = 2'b10,
    MODE_CDOWN = 2'b11
  } mode_t;

  mode_t           mode_q, mode_d;
  logic [N-1:0]    select_q, select_d;
  logic            blink_q, blink_d;
  logic            alarm_q, alarm_d;
  logic            inc_pulse_q, dec_pulse_q;
  logic [TO_W-1:0] to_cnt;
  logic            btn_mode_q, btn_next_q, btn_inc_q, btn_dec_q;

  // ---------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------
  logic mode_rise, next_rise, inc_rise, dec_rise, any_rise;
  logic fire_inc, fire_dec;
  logic rep_inc, rep_dec;
  logic set_stay;
  logic to_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_mode_q <= 1'b0;
      btn_next_q <= 1'b0;
      btn_inc_q  <= 1'b0;
      btn_dec_q  <= 1'b0;
    end else begin
      btn_mode_q <= btn_mode;
      btn_next_q <= btn_next;
      btn_inc_q  <= btn_inc;
      btn_dec_q  <= btn_dec;
    end
  end

  assign mode_rise = btn_mode & ~btn_mode_q;
  assign next_rise = btn_next & ~btn_next_q;
  assign inc_rise  = btn_inc  & ~btn_inc_q;
  assign dec_rise  = btn_dec  & ~btn_dec_q;
  assign any_rise  = mode_rise | next_rise | inc_rise | dec_rise;

  // A rise while the opposite button is held is a conflicting press: no pulse.
  assign fire_inc = inc_rise & ~btn_dec;
  assign fire_dec = dec_rise & ~btn_inc;

  // Remaining in SET across this edge; pulses and the timeout only live here.
  assign set_stay = (mode_q == MODE_SET) && (mode_d == MODE_SET);

  // ---------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------
`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             single_held;
  logic             rep_fire;

  assign single_held = btn_inc ^ btn_dec;

  // Down-counter: loaded on the rise so terminal count 1 lands REPEAT_DELAY-1
  // cycles later (pulse visible REPEAT_DELAY cycles after the rise), then
  // reloaded with REPEAT_PERIOD for the steady repeat rate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if (mode_q != MODE_SET || !single_held) begin
      rep_cnt <= '0;
    end else if (inc_rise | dec_rise) begin
      rep_cnt <= REP_W'(REPEAT_DELAY - 1);
    end else if (rep_cnt == REP_W'(1)) begin
      rep_cnt <= REP_W'(REPEAT_PERIOD);
    end else if (rep_cnt != '0) begin
      rep_cnt <= rep_cnt - 1'b1;
    end
  end

  assign rep_fire = (mode_q == MODE_SET) && single_held && !(inc_rise | dec_rise)
                    && (rep_cnt == REP_W'(1));
  assign rep_inc  = rep_fire & btn_inc;
  assign rep_dec  = rep_fire & btn_dec;
`else
  assign rep_inc = 1'b0;
  assign rep_dec = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // SET inactivity timeout (saturating up-counter of sec_tick)
  // ---------------------------------------------------------------------
  assign to_hit = (to_cnt == TO_W'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (!set_stay) begin
      to_cnt <= '0;
    end else if (any_rise | rep_inc | rep_dec) begin
      to_cnt <= '0;
    end else if (sec_tick && !to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= MODE_RUN;
      select_q    <= {{(N-1){1'b0}}, 1'b1};
      blink_q     <= 1'b0;
      alarm_q     <= 1'b0;
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      select_q    <= select_d;
      blink_q     <= blink_d;
      alarm_q     <= alarm_d;
      inc_pulse_q <= set_stay & (fire_inc | rep_inc);
      dec_pulse_q <= set_stay & (fire_dec | rep_dec);
    end
  end

  always_comb begin
    mode_d  = mode_q;
    alarm_d = 1'b0;
    unique case (mode_q)
      MODE_RUN: begin
        if (mode_rise) mode_d = MODE_SET;
      end
      MODE_SET: begin
        if (mode_rise)   mode_d = MODE_CDOWN;
        else if (to_hit) mode_d = MODE_RUN;
      end
      MODE_CDOWN: begin
        // End of countdown outranks a simultaneous mode press.
        if (cnt_zero) begin
          mode_d  = MODE_HOLD;
          alarm_d = 1'b1;
        end else if (mode_rise) begin
          mode_d = MODE_HOLD;
        end
      end
      MODE_HOLD: begin
        if (mode_rise) mode_d = MODE_RUN;
      end
      default: mode_d = MODE_RUN;
    endcase
  end

  always_comb begin
    select_d = select_q;
    if (mode_q != MODE_SET && mode_d == MODE_SET) begin
      select_d = {{(N-1){1'b0}}, 1'b1};
    end else if (set_stay && next_rise) begin
      select_d = {select_q[N-2:0], select_q[N-1]};
    end
  end

  // Cleared whenever SET is not the next mode, so blink reads 0 outside SET
  // and restarts from 0 on every entry.
  always_comb begin
    blink_d = 1'b0;
    if (set_stay) blink_d = blink_q ^ sec_tick;
  end

  // ---------------------------------------------------------------------
  // Per-field steering
  // ---------------------------------------------------------------------
  always_comb begin
    inc = '0;
    dec = '0;
    en  = '1;
    unique case (mode_q)
      MODE_RUN: begin
        inc = {done_inc, sec_tick};
      end
      MODE_SET: begin
        inc = inc_pulse_q ? select_q : '0;
        dec = dec_pulse_q ? select_q : '0;
        en  = select_q;
      end
      MODE_HOLD: begin
        inc = '0;
      end
      MODE_CDOWN: begin
        dec = {done_dec, sec_tick} & {N{~cnt_zero}};
      end
      default: begin
        inc = '0;
      end
    endcase
  end

  assign mode   = mode_q;
  assign select = select_q;
  assign blink  = blink_q;
  assign alarm  = alarm_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl
//   Directed bench for clock_mode_ctrl with default parameters
//   (NUM_FIELDS=6, REPEAT_DELAY=500, REPEAT_PERIOD=100, TIMEOUT=30).
//   Inputs change just after the falling edge; outputs are read #1 later.

module tb_clock_mode_ctrl;

  localparam int NF = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sec_tick = 1'b0;
  logic          btn_mode = 1'b0;
  logic          btn_next = 1'b0;
  logic          btn_inc = 1'b0;
  logic          btn_dec = 1'b0;
  logic [NF-2:0] done_inc = '0;
  logic [NF-2:0] done_dec = '0;
  logic          cnt_zero = 1'b0;
  logic [1:0]    mode;
  logic [NF-1:0] select;
  logic [NF-1:0] inc;
  logic [NF-1:0] dec;
  logic [NF-1:0] en;
  logic          blink;
  logic          alarm;

  int n_chk = 0;
  int n_bad = 0;

  clock_mode_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .sec_tick (sec_tick),
    .btn_mode (btn_mode),
    .btn_next (btn_next),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .done_inc (done_inc),
    .done_dec (done_dec),
    .cnt_zero (cnt_zero),
    .mode     (mode),
    .select   (select),
    .inc      (inc),
    .dec      (dec),
    .en       (en),
    .blink    (blink),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc(1);
    btn_mode = 1'b0;
    cyc(1);
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    cyc(1);
    btn_next = 1'b0;
    cyc(1);
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    cyc(1);
    sec_tick = 1'b0;
    cyc(1);
  endtask

  logic [NF-1:0] sel_tab [6] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
  int            exp_pos [4] = '{1, 500, 600, 700};
  int            pos     [8];
  int            npulse;
  int            exp_n;

  initial begin
    // reset state
    cyc(1);
    #1;
    check("rst_mode",   mode,   2'b00);
    check("rst_select", select, 6'h01);
    check("rst_inc",    inc,    6'h00);
    check("rst_dec",    dec,    6'h00);
    check("rst_en",     en,     6'h3F);
    check("rst_blink",  blink,  1'b0);
    check("rst_alarm",  alarm,  1'b0);
    reset = 1'b0;
    cyc(1);

    // RUN steering
    #1 check("run_inc_idle0", inc, 6'h00);
    done_inc = 5'b00011;
    sec_tick = 1'b1;
    #1;
    check("run_inc_tick", inc, 6'h07);
    check("run_dec",      dec, 6'h00);
    check("run_en",       en,  6'h3F);
    cyc(1);
    sec_tick = 1'b0;
    done_inc = 5'b00000;
    #1 check("run_inc_idle", inc, 6'h00);
    cyc(1);
    done_inc = 5'b10101;
    sec_tick = 1'b1;
    done_dec = 5'b11111;
    #1;
    check("run_inc_pat", inc, 6'h2B);
    check("run_dec_pat", dec, 6'h00);
    cyc(1);
    done_inc = '0;
    done_dec = '0;
    sec_tick = 1'b0;
    cyc(1);

    // enter SET and walk the field pointer
    press_mode();
    #1;
    check("set_mode",   mode,   2'b01);
    check("set_select", select, 6'h01);
    check("set_en",     en,     6'h01);
    check("set_blink",  blink,  1'b0);
    for (int i = 0; i < 6; i++) begin
      press_next();
      #1;
      check("next_select", select, sel_tab[i]);
      check("next_en",     en,     sel_tab[i]);
    end
    press_next();
    press_next();
    #1 check("sel_field2", select, 6'h04);

    // single inc pulse, one cycle after the rise
    btn_inc = 1'b1;
    #1 check("inc_rise_cyc", inc, 6'h00);
    cyc(1);
    #1;
    check("inc_pulse", inc, 6'h04);
    check("inc_pulse_dec", dec, 6'h00);
    cyc(1);
    #1 check("inc_after", inc, 6'h00);
    cyc(20);
    #1 check("inc_held", inc, 6'h00);
    btn_inc = 1'b0;
    cyc(1);

    // single dec pulse
    btn_dec = 1'b1;
    cyc(1);
    #1;
    check("dec_pulse", dec, 6'h04);
    check("dec_pulse_inc", inc, 6'h00);
    btn_dec = 1'b0;
    cyc(1);
    #1 check("dec_after", dec, 6'h00);

    // both buttons together: nothing
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    cyc(1);
    #1;
    check("both_inc1", inc, 6'h00);
    check("both_dec1", dec, 6'h00);
    cyc(1);
    #1;
    check("both_inc2", inc, 6'h00);
    check("both_dec2", dec, 6'h00);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    cyc(1);

    // blink
    tick();
    #1 check("blink_t1", blink, 1'b1);
    tick();
    #1 check("blink_t2", blink, 1'b0);

    // timeout restarted by a rise on tick 29
    btn_inc = 1'b1;
    cyc(1);
    btn_inc = 1'b0;
    cyc(1);
    repeat (28) tick();
    btn_inc = 1'b1;
    sec_tick = 1'b1;
    cyc(1);
    btn_inc = 1'b0;
    sec_tick = 1'b0;
    cyc(1);
    tick();
    cyc(3);
    #1 check("to_rise_at29", mode, 2'b01);

    // full idle timeout
    btn_inc = 1'b1;
    cyc(1);
    btn_inc = 1'b0;
    cyc(1);
    repeat (29) tick();
    cyc(3);
    #1 check("to_tick29", mode, 2'b01);
    sec_tick = 1'b1;
    cyc(1);
    sec_tick = 1'b0;
    #1 check("to_tick30_pend", mode, 2'b01);
    cyc(1);
    #1;
    check("to_expired", mode, 2'b00);
    check("to_blink",   blink, 1'b0);

    // SET -> COUNTDOWN
    press_mode();
    #1 check("reenter_sel", select, 6'h01);
    press_mode();
    #1 check("cd_mode", mode, 2'b11);
    sec_tick = 1'b1;
    done_dec = 5'b00001;
    #1;
    check("cd_dec",  dec, 6'h03);
    check("cd_inc",  inc, 6'h00);
    check("cd_en",   en,  6'h3F);
    cyc(1);
    done_dec = 5'b00000;
    cnt_zero = 1'b1;
    btn_mode = 1'b1;
    #1;
    check("cd_zero_dec", dec, 6'h00);
    check("cd_zero_alarm0", alarm, 1'b0);
    cyc(1);
    sec_tick = 1'b0;
    cnt_zero = 1'b0;
    btn_mode = 1'b0;
    #1;
    check("cd_end_mode",  mode,  2'b10);
    check("cd_end_alarm", alarm, 1'b1);
    check("hold_dec",     dec,   6'h00);
    check("hold_en",      en,    6'h3F);
    cyc(1);
    #1;
    check("alarm_one_cyc", alarm, 1'b0);
    check("hold_stays",    mode,  2'b10);
    press_mode();
    #1 check("hold_to_run", mode, 2'b00);

    // asynchronous reset in the middle of SET
    press_mode();
    press_next();
    press_next();
    #1 check("pre_rst_sel", select, 6'h04);
    reset = 1'b1;
    #1;
    check("mid_rst_mode",   mode,   2'b00);
    check("mid_rst_select", select, 6'h01);
    check("mid_rst_inc",    inc,    6'h00);
    check("mid_rst_dec",    dec,    6'h00);
    check("mid_rst_en",     en,     6'h3F);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // held inc button: pulse positions relative to the rise
    press_mode();
    npulse = 0;
    btn_inc = 1'b1;
    for (int k = 1; k <= 802; k++) begin
      cyc(1);
      if (k == 799) btn_inc = 1'b0;
      #1;
      if (inc != '0) begin
        if (npulse < 8) pos[npulse] = k;
        npulse++;
      end
    end
`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    check("hold_pulse_count", npulse, exp_n);
    for (int i = 0; i < exp_n && i < npulse; i++) begin
      check("hold_pulse_pos", pos[i], exp_pos[i]);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Parametrised, registered successor to the combinational mode/field decoder of the digital clock.
- Owns the operating-mode FSM and the one-hot field-select pointer.
- Edge-detects the mode, next, inc and dec buttons, with auto-repeat.
- Drives per-field inc/dec/en vectors into a chain of NUM_FIELDS cascaded digit counters.

Parameters:
- NUM_FIELDS, 6, number of cascaded counter fields (>=2)
- REPEAT_DELAY, 500, clk cycles a held inc/dec button waits before auto-repeat starts (>=2)
- REPEAT_PERIOD, 100, clk cycles between auto-repeat pulses (>=2)
- TIMEOUT, 30, sec_tick strobes in SET without any button edge before returning to RUN (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sec_tick  in  1  one-cycle time-base strobe
- btn_mode  in  1  mode button, synchronised and debounced level
- btn_next  in  1  field-advance button, level
- btn_inc  in  1  increment button, level
- btn_dec  in  1  decrement button, level
- done_inc  in  NUM_FIELDS-1  carry-out of field i (max value reached while inc active)
- done_dec  in  NUM_FIELDS-1  borrow-out of field i
- cnt_zero  in  1  all fields equal zero
- mode  out  2  current mode
- select  out  NUM_FIELDS  one-hot field pointer
- inc  out  NUM_FIELDS  per-field increment enable
- dec  out  NUM_FIELDS  per-field decrement enable
- en  out  NUM_FIELDS  per-field load/display enable
- blink  out  1  blink phase for the selected field
- alarm  out  1  one-cycle pulse at end of countdown

Behaviour:
- Reset (asynchronous, active-high): mode=RUN(00), select=1 (bit 0), blink=0, alarm=0. All edge, repeat and timeout registers are cleared. inc=0 until the first sec_tick; dec=0.
- Edges: rise = btn & ~btn_q, where btn_q is a 1-cycle delayed copy of the button.
- Modes: RUN=00, SET=01, HOLD=10, COUNTDOWN=11.
- Mode-change priority (highest first): cnt_zero in COUNTDOWN, then btn_mode rise, then SET timeout, then btn_next rise.
- Transitions on btn_mode rise: RUN->SET, SET->COUNTDOWN, COUNTDOWN->HOLD, HOLD->RUN.
  - Entering SET forces select=1, clears the timeout counter and sets blink=0.
- COUNTDOWN with cnt_zero=1: next state HOLD; alarm=1 for exactly one cycle. A btn_mode rise in the same cycle is ignored.
- SET timeout: the counter increments on each sec_tick and clears on any button rise. When it reaches TIMEOUT, next state is RUN.
- btn_next rise in SET: select rotates left by 1; the MSB wraps to bit 0. btn_next is ignored in other modes.
- inc/dec/en are combinational from the registered mode plus inputs.
  - RUN: inc[0]=sec_tick; inc[i]=done_inc[i-1] for i>=1; dec=0; en=all ones.
  - SET: inc=set_inc_pulse ? select : 0; dec=set_dec_pulse ? select : 0; en=select.
  - HOLD: inc=0, dec=0, en=all ones.
  - COUNTDOWN: dec[0]=sec_tick & ~cnt_zero; dec[i]=done_dec[i-1] & ~cnt_zero; inc=0; en=all ones.
- set_inc_pulse / set_dec_pulse:
  - Registered, one cycle long, asserted the cycle after the button rise.
  - Both btn_inc and btn_dec high together: no pulses, and the repeat counter is held at 0.
  - Leaving SET clears both pulses, even if the button is still held.
- blink: toggles on each sec_tick in SET; 0 in all other modes.
- Widths: counters sized with $clog2(param+1). The timeout counter saturates and never wraps.

Optional Feature:
- Macro: CLOCK_MODE_CTRL_AUTO_REPEAT_EN.
- Defined:
  - While a single inc/dec button stays held in SET, the first pulse fires on the rise.
  - The next pulse fires REPEAT_DELAY cycles after the rise, then one every REPEAT_PERIOD cycles until release.
  - Each repeat pulse also clears the timeout counter.
- Undefined: exactly one pulse per rise; REPEAT_DELAY and REPEAT_PERIOD are unused.

Test Plan:
- Reset mid-SET with select=0b000100 -> mode=00, select=0b000001, inc=0, dec=0, en=0b111111 in the same cycle.
- RUN, done_inc=0b00011, sec_tick pulse -> inc=0b000111 during that cycle; inc=0 otherwise.
- btn_mode rise, then 6x btn_next rises -> mode=01, select walks 0b000010..0b100000 then wraps to 0b000001; en tracks select.
- SET, select=0b000100, btn_inc rise -> inc=0b000100 for exactly 1 cycle, 1 cycle after the rise. btn_inc+btn_dec held together -> no pulses.
- SET idle for 30 sec_ticks -> mode=00 after the 30th tick. A button rise at tick 29 -> still in SET at tick 30.
- COUNTDOWN, cnt_zero asserted together with a btn_mode rise -> alarm=1 for 1 cycle, mode=10, dec=0. With AUTO_REPEAT_EN and btn_inc held 800 cycles -> 4 pulses, at cycles 1, 500, 600 and 700 after the rise.
